// File: rtl/game_flow_pkg.sv
// Shared types and defaults for the game flow sequencer.
package game_flow_pkg;

  localparam int unsigned LEVEL_W = 3;

  localparam int unsigned DEF_FREEZE_FRAMES = 60;
  localparam int unsigned DEF_SCREEN_FRAMES = 180;
  localparam int unsigned DEF_RESET_CYCLES  = 4;
  localparam int unsigned DEF_MAX_LEVEL     = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESTART    = 3'd1,
    PLAYING    = 3'd2,
    HIT_FREEZE = 3'd3,
    LOST       = 3'd4,
    WON        = 3'd5
  } game_state_t;

  // Larger of two unsigned values.
  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxVal, never less than one.
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal == 0) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter, saturating at zero, with a registered zero flag.
module frame_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] nextCount;

  // Load wins over counting; counting stops at zero.
  always_comb begin
    nextCount = count;
    if (load) begin
      nextCount = loadValue;
    end else if (enable && (count != '0)) begin
      nextCount = count - WIDTH'(1);
    end
  end

  // Count register and its zero flag.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= nextCount;
      zero  <= (nextCount == '0);
    end
  end

endmodule

// File: rtl/game_flow_fsm.sv
// Top-level game sequencer: title, restart, play, hit freeze, lose and win screens.
module game_flow_fsm
  import game_flow_pkg::*;
#(
  parameter int unsigned FREEZE_FRAMES = DEF_FREEZE_FRAMES,
  parameter int unsigned SCREEN_FRAMES = DEF_SCREEN_FRAMES,
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned MAX_LEVEL     = DEF_MAX_LEVEL
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               lost,
  input  logic               allAliensDead,
  input  logic               playerHitPulse,
  output logic               gameplayResetN,
  output logic               freeze,
  output logic [LEVEL_W-1:0] level,
  output logic               showTitle,
  output logic               showLose,
  output logic               showWin
);

  localparam int unsigned CYC_W   = cntWidth(RESET_CYCLES);
  localparam int unsigned FRAME_W = cntWidth(maxU(FREEZE_FRAMES, SCREEN_FRAMES));

  game_state_t        state;
  game_state_t        stateNext;
  logic [LEVEL_W-1:0] levelNext;
  logic               startKeyD;
  logic               startEdge;

  logic               cycLoad;
  logic [CYC_W-1:0]   cycCount;
  logic               cycZero;

  logic               frameLoad;
  logic [FRAME_W-1:0] frameLoadValue;
  logic [FRAME_W-1:0] frameCount;
  logic               frameZero;

  logic               gameplayResetNNext;
  logic               freezeNext;
  logic               showTitleNext;
  logic               showLoseNext;
  logic               showWinNext;

  assign startEdge = startKey & ~startKeyD;

  // Clock-enabled counter timing the gameplay reset pulse.
  frame_down_counter #(
    .WIDTH (CYC_W)
  ) cycleCounter (
    .clk       (clk),
    .resetN    (resetN),
    .load      (cycLoad),
    .loadValue (CYC_W'(RESET_CYCLES)),
    .enable    (1'b1),
    .count     (cycCount),
    .zero      (cycZero)
  );

  // Frame-enabled counter shared by the hit freeze and the end screens.
  frame_down_counter #(
    .WIDTH (FRAME_W)
  ) frameCounter (
    .clk       (clk),
    .resetN    (resetN),
    .load      (frameLoad),
    .loadValue (frameLoadValue),
    .enable    (startOfFrame),
    .count     (frameCount),
    .zero      (frameZero)
  );

  // Next-state, level and counter-load decisions.
  always_comb begin
    stateNext      = state;
    levelNext      = level;
    cycLoad        = 1'b0;
    frameLoad      = 1'b0;
    frameLoadValue = '0;

    case (state)
      IDLE: begin
        if (startEdge) begin
          stateNext = RESTART;
          levelNext = '0;
          cycLoad   = 1'b1;
        end
      end

      RESTART: begin
        // Leave on the edge that takes the counter from one to zero.
        if (cycZero || (cycCount == CYC_W'(1))) begin
          stateNext = PLAYING;
        end
      end

      PLAYING: begin
        if (lost) begin
          stateNext      = LOST;
          frameLoad      = 1'b1;
          frameLoadValue = FRAME_W'(SCREEN_FRAMES);
        end else if (allAliensDead) begin
          if (level == LEVEL_W'(MAX_LEVEL)) begin
            stateNext      = WON;
            frameLoad      = 1'b1;
            frameLoadValue = FRAME_W'(SCREEN_FRAMES);
          end else begin
            stateNext = RESTART;
            levelNext = level + LEVEL_W'(1);
            cycLoad   = 1'b1;
          end
        end else if (playerHitPulse) begin
          stateNext      = HIT_FREEZE;
          frameLoad      = 1'b1;
          frameLoadValue = FRAME_W'(FREEZE_FRAMES);
        end
      end

      HIT_FREEZE: begin
        // Extra hits are ignored here so the freeze is never extended.
        if (lost) begin
          stateNext      = LOST;
          frameLoad      = 1'b1;
          frameLoadValue = FRAME_W'(SCREEN_FRAMES);
        end else if (frameZero || (startOfFrame && (frameCount == FRAME_W'(1)))) begin
          stateNext = PLAYING;
        end
      end

      LOST, WON: begin
        // A press before the screen times out is simply dropped.
        if (startEdge && frameZero) begin
          stateNext = RESTART;
          levelNext = '0;
          cycLoad   = 1'b1;
        end
      end

      default: begin
        stateNext = IDLE;
        levelNext = '0;
      end
    endcase
  end

  // Output decode of the upcoming state, registered alongside it.
  always_comb begin
    gameplayResetNNext = 1'b1;
    freezeNext         = 1'b0;
    showTitleNext      = 1'b0;
    showLoseNext       = 1'b0;
    showWinNext        = 1'b0;
    case (stateNext)
      IDLE: begin
        gameplayResetNNext = 1'b0;
        freezeNext         = 1'b1;
        showTitleNext      = 1'b1;
      end
      RESTART:    gameplayResetNNext = 1'b0;
      HIT_FREEZE: freezeNext = 1'b1;
      LOST: begin
        freezeNext   = 1'b1;
        showLoseNext = 1'b1;
      end
      WON: begin
        freezeNext  = 1'b1;
        showWinNext = 1'b1;
      end
      default: ;
    endcase
  end

  // State, level, key history and output registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      level          <= '0;
      startKeyD      <= 1'b0;
      gameplayResetN <= 1'b0;
      freeze         <= 1'b1;
      showTitle      <= 1'b1;
      showLose       <= 1'b0;
      showWin        <= 1'b0;
    end else begin
      state          <= stateNext;
      level          <= levelNext;
      startKeyD      <= startKey;
      gameplayResetN <= gameplayResetNNext;
      freeze         <= freezeNext;
      showTitle      <= showTitleNext;
      showLose       <= showLoseNext;
      showWin        <= showWinNext;
    end
  end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Self-checking bench for game_flow_fsm with a behavioural game-flow model.
module tb_game_flow_fsm;

  localparam int FREEZE_F = 60;
  localparam int SCREEN_F = 180;
  localparam int RESET_C  = 4;
  localparam int MAX_L    = 7;

  localparam int M_TITLE  = 0;
  localparam int M_RESET  = 1;
  localparam int M_PLAY   = 2;
  localparam int M_FREEZE = 3;
  localparam int M_LOSE   = 4;
  localparam int M_WIN    = 5;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       startKey = 1'b0;
  logic       lost = 1'b0;
  logic       allAliensDead = 1'b0;
  logic       playerHitPulse = 1'b0;
  logic       gameplayResetN;
  logic       freeze;
  logic [2:0] level;
  logic       showTitle;
  logic       showLose;
  logic       showWin;

  int total = 0;
  int bad   = 0;

  // Reference model: what the player sees, plus "how much longer" for timed phases.
  int mMode    = M_TITLE;
  int mLevel   = 0;
  int mLeft    = 0;
  bit mKeyPrev = 1'b0;

  game_flow_fsm #(
    .FREEZE_FRAMES (FREEZE_F),
    .SCREEN_FRAMES (SCREEN_F),
    .RESET_CYCLES  (RESET_C),
    .MAX_LEVEL     (MAX_L)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .startKey       (startKey),
    .lost           (lost),
    .allAliensDead  (allAliensDead),
    .playerHitPulse (playerHitPulse),
    .gameplayResetN (gameplayResetN),
    .freeze         (freeze),
    .level          (level),
    .showTitle      (showTitle),
    .showLose       (showLose),
    .showWin        (showWin)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input bit sof, input bit key, input bit lst,
                           input bit aad, input bit hit, input bit rst);
    bit pressed;
    pressed  = key && !mKeyPrev;
    mKeyPrev = rst ? key : 1'b0;
    if (!rst) begin
      mMode  = M_TITLE;
      mLevel = 0;
      mLeft  = 0;
      return;
    end
    case (mMode)
      M_TITLE: if (pressed) begin mMode = M_RESET; mLevel = 0; mLeft = RESET_C; end
      M_RESET: begin
        mLeft = mLeft - 1;
        if (mLeft == 0) mMode = M_PLAY;
      end
      M_PLAY: begin
        if (lst) begin
          mMode = M_LOSE; mLeft = SCREEN_F;
        end else if (aad) begin
          if (mLevel == MAX_L) begin
            mMode = M_WIN; mLeft = SCREEN_F;
          end else begin
            mLevel = mLevel + 1; mMode = M_RESET; mLeft = RESET_C;
          end
        end else if (hit) begin
          mMode = M_FREEZE; mLeft = FREEZE_F;
        end
      end
      M_FREEZE: begin
        if (lst) begin
          mMode = M_LOSE; mLeft = SCREEN_F;
        end else if (sof) begin
          mLeft = mLeft - 1;
          if (mLeft == 0) mMode = M_PLAY;
        end
      end
      default: begin
        if (pressed && mLeft == 0) begin
          mMode = M_RESET; mLevel = 0; mLeft = RESET_C;
        end else if (sof && mLeft > 0) begin
          mLeft = mLeft - 1;
        end
      end
    endcase
  endtask

  function automatic logic [7:0] expVec();
    logic g, f, t, l, w;
    g = !(mMode == M_TITLE || mMode == M_RESET);
    f = (mMode == M_TITLE || mMode == M_FREEZE || mMode == M_LOSE || mMode == M_WIN);
    t = (mMode == M_TITLE);
    l = (mMode == M_LOSE);
    w = (mMode == M_WIN);
    return {g, f, 3'(mLevel), t, l, w};
  endfunction

  function automatic logic [7:0] dutVec();
    return {gameplayResetN, freeze, level, showTitle, showLose, showWin};
  endfunction

  // Apply one clock of inputs to both the DUT and the model.
  task automatic tick(input bit sof, input bit key, input bit lst,
                      input bit aad, input bit hit, input bit rst);
    startOfFrame   = sof;
    startKey       = key;
    lost           = lst;
    allAliensDead  = aad;
    playerHitPulse = hit;
    resetN         = rst;
    @(posedge clk);
    modelStep(sof, key, lst, aad, hit, rst);
    #1;
  endtask

  // Clock through a restart, counting clocks with gameplay held in reset.
  task automatic runRestart(output int cycles, output bit timedOut);
    cycles   = 0;
    timedOut = 1'b0;
    while (!gameplayResetN) begin
      if (cycles >= 20) begin
        timedOut = 1'b1;
        break;
      end
      cycles++;
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dutVec() !== 8'b0100_0100) begin
      bad++; $display("FAIL reset_state: got %b want %b", dutVec(), 8'b0100_0100);
    end
    repeat ($urandom_range(2, 6)) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (dutVec() !== expVec()) begin
        bad++; $display("FAIL reset_idle: got %b want %b", dutVec(), expVec());
      end
    end
  endtask

  task automatic test_start();
    int cnt;
    bit to;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (showTitle !== 1'b0 || gameplayResetN !== 1'b0) begin
      bad++; $display("FAIL start_enter: title=%b gprn=%b want 0 0", showTitle, gameplayResetN);
    end
    runRestart(cnt, to);
    total++;
    if (to || cnt != RESET_C) begin
      bad++; $display("FAIL start_restart_len: got %0d clocks (timeout=%0d) want %0d", cnt, to, RESET_C);
    end
    total++;
    if (level !== 3'd0 || freeze !== 1'b0 || dutVec() !== expVec()) begin
      bad++; $display("FAIL start_playing: got %b want %b", dutVec(), expVec());
    end
  endtask

  task automatic test_hit();
    int pulses;
    int guard;
    bit sof;
    bit hit;
    repeat ($urandom_range(1, 5)) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (freeze !== 1'b1 || dutVec() !== expVec()) begin
      bad++; $display("FAIL hit_enter: got %b want %b", dutVec(), expVec());
    end
    pulses = 0;
    guard  = 0;
    while (freeze === 1'b1 && guard < 2000) begin
      sof = ($urandom_range(0, 2) == 0);
      hit = (pulses == 30) || ($urandom_range(0, 9) == 0);
      if (sof) pulses++;
      tick(sof, 1'b0, 1'b0, 1'b0, hit, 1'b1);
      total++;
      if (dutVec() !== expVec()) begin
        bad++; $display("FAIL hit_track pulse %0d: got %b want %b", pulses, dutVec(), expVec());
      end
      guard++;
    end
    total++;
    if (pulses != FREEZE_F) begin
      bad++; $display("FAIL hit_length: got %0d frame pulses want %0d", pulses, FREEZE_F);
    end
  endtask

  task automatic test_levels();
    int cnt;
    bit to;
    for (int lv = 0; lv < MAX_L; lv++) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'(lv % 2), 1'b1);
      total++;
      if (gameplayResetN !== 1'b0 || dutVec() !== expVec()) begin
        bad++; $display("FAIL level_adv %0d: got %b want %b", lv, dutVec(), expVec());
      end
      runRestart(cnt, to);
      total++;
      if (to || cnt != RESET_C || level !== 3'(lv + 1)) begin
        bad++; $display("FAIL level_restart %0d: got %0d clocks level %0d want %0d level %0d",
                        lv, cnt, level, RESET_C, lv + 1);
      end
      repeat ($urandom_range(0, 3)) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (showWin !== 1'b1 || level !== 3'd7 || freeze !== 1'b1 || dutVec() !== expVec()) begin
      bad++; $display("FAIL level_win: got %b want %b", dutVec(), expVec());
    end
    for (int p = 0; p < SCREEN_F; p++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (showWin !== 1'b0 || gameplayResetN !== 1'b0 || level !== 3'd0) begin
      bad++; $display("FAIL win_restart: got %b want %b", dutVec(), 8'b0000_0000);
    end
    runRestart(cnt, to);
    total++;
    if (to || dutVec() !== expVec()) begin
      bad++; $display("FAIL win_replay: got %b want %b", dutVec(), expVec());
    end
  endtask

  task automatic test_lost_combo();
    int cnt;
    bit to;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    runRestart(cnt, to);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (showLose !== 1'b1 || level !== 3'd1 || dutVec() !== expVec()) begin
      bad++; $display("FAIL lost_combo: got %b want %b", dutVec(), expVec());
    end
    for (int p = 1; p <= SCREEN_F; p++) begin
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (p == 100 || p == SCREEN_F - 1) begin
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (showLose !== 1'b1 || gameplayResetN !== 1'b1 || dutVec() !== expVec()) begin
          bad++; $display("FAIL lost_early_press frame %0d: got %b want %b", p, dutVec(), expVec());
        end
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (showLose !== 1'b0 || gameplayResetN !== 1'b0 || level !== 3'd0) begin
      bad++; $display("FAIL lost_restart: got %b want %b", dutVec(), 8'b0000_0000);
    end
    runRestart(cnt, to);
    total++;
    if (to || dutVec() !== expVec()) begin
      bad++; $display("FAIL lost_replay: got %b want %b", dutVec(), expVec());
    end
  endtask

  task automatic test_held_key();
    int cnt;
    bit to;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < SCREEN_F + 10; p++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (showLose !== 1'b1 || dutVec() !== expVec()) begin
      bad++; $display("FAIL held_key: got %b want %b", dutVec(), expVec());
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (showLose !== 1'b0 || gameplayResetN !== 1'b0) begin
      bad++; $display("FAIL held_repress: got %b want %b", dutVec(), expVec());
    end
    runRestart(cnt, to);
    total++;
    if (to || dutVec() !== expVec()) begin
      bad++; $display("FAIL held_replay: got %b want %b", dutVec(), expVec());
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    bit to;
    repeat (3) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      runRestart(cnt, to);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (level !== 3'd3 || freeze !== 1'b1 || dutVec() !== expVec()) begin
      bad++; $display("FAIL midreset_setup: got %b want %b", dutVec(), expVec());
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (dutVec() !== 8'b0100_0100) begin
      bad++; $display("FAIL midreset_idle: got %b want %b", dutVec(), 8'b0100_0100);
    end
  endtask

  task automatic test_random();
    bit key;
    bit rst;
    key = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) key = ~key;
      rst = ($urandom_range(0, 999) != 0);
      tick(($urandom_range(0, 3) == 0), key, ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0), rst);
      total++;
      if (dutVec() !== expVec()) begin
        bad++; $display("FAIL random cyc %0d: got %b want %b", i, dutVec(), expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_levels();
    test_lost_combo();
    test_held_key();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
